// File: rtl/vend_countdown_timer.sv
// ----------------------------------------------------------------------------
// vend_countdown_timer
//
// Vending-machine transaction timeout. Counts a 2-digit BCD seconds value down
// from START_SECS on each 1 Hz trigger pulse. While the count is in the
// warning window it toggles a blink strobe on each 2 Hz pulse. When the count
// reaches zero it raises a one-cycle timeout pulse to the main vending FSM.
//
// Parameters
//   START_SECS  countdown load value in seconds (1..99)
//   WARN_SECS   warning window threshold, count <= WARN_SECS (0..START_SECS-1)
//
// Ports
//   clk         system clock; all logic on posedge
//   rst_n       asynchronous active-low reset
//   trig_1Hz    one-cycle pulse once per second
//   trig_2Hz    one-cycle pulse twice per second (coincides with trig_1Hz)
//   start       begin a countdown from IDLE or DONE
//   kick        reload the count while RUN/WARN (customer activity)
//   cancel      abort to IDLE from any state
//   secs_bcd    {tens,ones} BCD seconds remaining
//   busy        high in RUN or WARN
//   warn_blink  blink strobe, toggles on trig_2Hz in WARN, else 0
//   done        high in DONE
//   timeout     one-cycle pulse on entry to DONE
// ----------------------------------------------------------------------------
module vend_countdown_timer #(
    parameter int START_SECS = 30,
    parameter int WARN_SECS  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trig_1Hz,
    input  logic       trig_2Hz,
    input  logic       start,
    input  logic       kick,
    input  logic       cancel,
    output logic [7:0] secs_bcd,
    output logic       busy,
    output logic       warn_blink,
    output logic       done,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WARN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] START_TENS = 4'(START_SECS / 10);
    localparam logic [3:0] START_ONES = 4'(START_SECS % 10);
    localparam logic [7:0] START_BCD  = {START_TENS, START_ONES};
    localparam logic [6:0] WARN_BIN   = 7'(WARN_SECS);

    state_t     state_q, state_d;
    logic [7:0] secs_d;
    logic       blink_d;
    logic       timeout_d;

    logic [7:0] secs_dec;      // count after one BCD decrement
    logic [6:0] secs_dec_bin;  // same value in binary, for the window compare

    // BCD decrement with borrow from tens; saturates at 00.
    always_comb begin
        secs_dec = secs_bcd;
        if (secs_bcd != 8'h00) begin
            if (secs_bcd[3:0] == 4'd0) begin
                secs_dec = {secs_bcd[7:4] - 4'd1, 4'd9};
            end else begin
                secs_dec = {secs_bcd[7:4], secs_bcd[3:0] - 4'd1};
            end
        end
        secs_dec_bin = 7'(secs_dec[7:4]) * 7'd10 + 7'(secs_dec[3:0]);
    end

    // Next-state and next-output logic. cancel > kick > start > triggers;
    // a control input in the same cycle as a trigger swallows the trigger.
    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        secs_d    = secs_bcd;
        blink_d   = warn_blink;
        timeout_d = 1'b0;

        if (cancel) begin
            state_d = ST_IDLE;
            secs_d  = 8'h00;
            blink_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        secs_d  = START_BCD;
                        blink_d = 1'b0;
                    end
                end
                ST_RUN, ST_WARN: begin
                    if (kick) begin
                        state_d = ST_RUN;
                        secs_d  = START_BCD;
                        blink_d = 1'b0;
                    end else if (!start) begin
                        if (trig_1Hz) begin
                            secs_d = secs_dec;
                            if (secs_dec == 8'h00) begin
                                state_d   = ST_DONE;
                                timeout_d = 1'b1;
                                blink_d   = 1'b0;
                            end else if (secs_dec_bin <= WARN_BIN) begin
                                state_d = ST_WARN;
                                // Blink only advances once already in WARN.
                                if (state_q == ST_WARN && trig_2Hz) begin
                                    blink_d = ~warn_blink;
                                end
                            end else begin
                                state_d = ST_RUN;
                                blink_d = 1'b0;
                            end
                        end else if (state_q == ST_WARN && trig_2Hz) begin
                            blink_d = ~warn_blink;
                        end
                    end
                end
                ST_DONE: begin
                    secs_d  = 8'h00;
                    blink_d = 1'b0;
                    if (start) begin
                        state_d = ST_RUN;
                        secs_d  = START_BCD;
                    end
                end
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values computed above.
    // NOTE: all registers here are small control flops, so each one is reset;
    // a mid-count reset drops straight to idle without raising timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            secs_bcd   <= 8'h00;
            warn_blink <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            secs_bcd   <= secs_d;
            warn_blink <= blink_d;
            timeout    <= timeout_d;
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_WARN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_vend_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_vend_countdown_timer
//
// Self-checking bench. A behavioural model tracks the remaining seconds as a
// plain integer plus active/done flags and predicts every output. Directed
// sequences cover the countdown, warning blink, kick, cancel, restart from
// DONE, asynchronous reset and the one-second configuration; a randomized
// phase then drives all inputs with $urandom.
// ----------------------------------------------------------------------------
module tb_vend_countdown_timer;

    localparam int START = 30;
    localparam int WARN  = 5;

    logic       clk;
    logic       rst_n;
    logic       trig_1Hz, trig_2Hz, start, kick, cancel;
    logic [7:0] secs_bcd;
    logic       busy, warn_blink, done, timeout;

    logic       start1;
    logic [7:0] secs_bcd1;
    logic       busy1, warn_blink1, done1, timeout1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit m_active;
    bit m_done;
    int m_secs;
    bit m_blink;
    bit m_to;

    vend_countdown_timer #(.START_SECS(START), .WARN_SECS(WARN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_1Hz   (trig_1Hz),
        .trig_2Hz   (trig_2Hz),
        .start      (start),
        .kick       (kick),
        .cancel     (cancel),
        .secs_bcd   (secs_bcd),
        .busy       (busy),
        .warn_blink (warn_blink),
        .done       (done),
        .timeout    (timeout)
    );

    vend_countdown_timer #(.START_SECS(1), .WARN_SECS(0)) dut_one (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_1Hz   (trig_1Hz),
        .trig_2Hz   (trig_2Hz),
        .start      (start1),
        .kick       (kick),
        .cancel     (cancel),
        .secs_bcd   (secs_bcd1),
        .busy       (busy1),
        .warn_blink (warn_blink1),
        .done       (done1),
        .timeout    (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_done   = 0;
        m_secs   = 0;
        m_blink  = 0;
        m_to     = 0;
    endtask

    // One clock of the timeout behaviour, written in terms of seconds left.
    task automatic model_step(input bit s, input bit k, input bit c, input bit t1, input bit t2);
        bit in_warn;
        in_warn = m_active && (m_secs > 0) && (m_secs <= WARN);
        m_to = 0;
        if (c) begin
            m_active = 0; m_done = 0; m_secs = 0; m_blink = 0;
        end else if (m_active) begin
            if (k) begin
                m_secs = START; m_blink = 0;
            end else if (!s) begin
                if (t1) begin
                    if (m_secs > 0) m_secs = m_secs - 1;
                    if (m_secs == 0) begin
                        m_active = 0; m_done = 1; m_to = 1; m_blink = 0;
                    end else if (m_secs <= WARN) begin
                        if (in_warn && t2) m_blink = !m_blink;
                    end else begin
                        m_blink = 0;
                    end
                end else if (in_warn && t2) begin
                    m_blink = !m_blink;
                end
            end
        end else if (s) begin
            m_active = 1; m_done = 0; m_secs = START; m_blink = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".secs"},    32'(secs_bcd),   32'(to_bcd(m_secs)));
        check({tag, ".busy"},    32'(busy),       32'(m_active));
        check({tag, ".blink"},   32'(warn_blink), 32'(m_blink));
        check({tag, ".done"},    32'(done),       32'(m_done));
        check({tag, ".timeout"}, 32'(timeout),    32'(m_to));
    endtask

    // Drive one cycle of inputs, advance model and DUT, compare 1 time unit later.
    task automatic step(input string tag, input bit s, input bit k, input bit c,
                        input bit t1, input bit t2);
        start    = s;
        kick     = k;
        cancel   = c;
        trig_1Hz = t1;
        trig_2Hz = t2 | t1;
        @(posedge clk);
        model_step(s, k, c, t1, t2 | t1);
        #1;
        compare_all(tag);
    endtask

    task automatic step_exact(input string tag, input bit s, input bit k, input bit c,
                              input bit t1, input bit t2);
        start    = s;
        kick     = k;
        cancel   = c;
        trig_1Hz = t1;
        trig_2Hz = t2;
        @(posedge clk);
        model_step(s, k, c, t1, t2);
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [3:0] blink_seq;
        blink_seq = 4'b0101; // bit i = expected blink after i-th 2 Hz pulse

        rst_n = 1'b0;
        start = 0; kick = 0; cancel = 0; trig_1Hz = 0; trig_2Hz = 0; start1 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        check("reset.secs_const", 32'(secs_bcd), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Full countdown from 30 to 00
        step("t1.start", 1, 0, 0, 0, 0);
        check("t1.load", 32'(secs_bcd), 32'h30);
        for (int i = 1; i <= 30; i++) begin
            step_exact("t1.count", 0, 0, 0, 1, 0);
            if (i == 20) check("t1.at10", 32'(secs_bcd), 32'h10);
            if (i == 21) check("t1.borrow", 32'(secs_bcd), 32'h09);
        end
        check("t1.timeout_hi", 32'(timeout), 32'h1);
        check("t1.done", 32'(done), 32'h1);
        check("t1.busy", 32'(busy), 32'h0);
        step_exact("t1.after", 0, 0, 0, 0, 0);
        check("t1.timeout_lo", 32'(timeout), 32'h0);

        // 2. Warning window and blink
        step_exact("t2.start", 1, 0, 0, 0, 0);
        for (int i = 1; i <= 25; i++) step_exact("t2.count", 0, 0, 0, 1, 0);
        check("t2.secs05", 32'(secs_bcd), 32'h05);
        for (int i = 0; i < 4; i++) begin
            step_exact("t2.blink", 0, 0, 0, 0, 1);
            check("t2.blink_seq", 32'(warn_blink), 32'(blink_seq[i]));
        end
        step_exact("t2.coincident", 0, 0, 0, 1, 1);
        check("t2.co_secs", 32'(secs_bcd), 32'h04);
        check("t2.co_blink", 32'(warn_blink), 32'h1);
        step_exact("t2.secs03", 0, 0, 0, 1, 0);
        check("t2.hold_blink", 32'(warn_blink), 32'h1);

        // 3. kick in WARN reloads
        step_exact("t3.kick", 0, 1, 0, 0, 0);
        check("t3.secs", 32'(secs_bcd), 32'h30);
        check("t3.blink", 32'(warn_blink), 32'h0);
        step_exact("t3.run_2hz", 0, 0, 0, 0, 1);

        // 4. cancel + kick + trig in RUN
        step_exact("t4.cancel", 0, 1, 1, 1, 1);
        check("t4.secs", 32'(secs_bcd), 32'h00);
        check("t4.busy", 32'(busy), 32'h0);

        // 5. restart from DONE with a coincident trig
        step_exact("t5.start", 1, 0, 0, 0, 0);
        for (int i = 1; i <= 30; i++) step_exact("t5.count", 0, 0, 0, 1, 0);
        step_exact("t5.restart", 1, 0, 0, 1, 1);
        check("t5.secs", 32'(secs_bcd), 32'h30);
        check("t5.busy", 32'(busy), 32'h1);
        step_exact("t5.start_in_run", 1, 0, 0, 1, 1);

        // 6. asynchronous reset in WARN
        for (int i = 1; i <= 26; i++) step_exact("t6.count", 0, 0, 0, 1, 0);
        step_exact("t6.blink", 0, 0, 0, 0, 1);
        check("t6.pre_blink", 32'(warn_blink), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("t6.async");
        @(negedge clk);
        rst_n = 1'b1;

        // 6b. one-second configuration
        start1 = 1'b1;
        step_exact("t6b.start", 0, 0, 0, 0, 0);
        start1 = 1'b0;
        check("t6b.load", 32'(secs_bcd1), 32'h01);
        check("t6b.busy", 32'(busy1), 32'h1);
        step_exact("t6b.trig", 0, 0, 0, 1, 1);
        check("t6b.secs", 32'(secs_bcd1), 32'h00);
        check("t6b.timeout", 32'(timeout1), 32'h1);
        check("t6b.done", 32'(done1), 32'h1);
        check("t6b.blink", 32'(warn_blink1), 32'h0);
        step_exact("t6b.after", 0, 0, 0, 0, 0);
        check("t6b.timeout_lo", 32'(timeout1), 32'h0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            bit rs, rk, rc, r1, r2;
            rc = ($urandom_range(0, 99) < 2);
            rk = ($urandom_range(0, 99) < 3);
            rs = ($urandom_range(0, 99) < 6);
            r1 = ($urandom_range(0, 99) < 40);
            r2 = r1 | ($urandom_range(0, 99) < 40);
            step_exact("rand", rs, rk, rc, r1, r2);
        end

        start = 0; kick = 0; cancel = 0; trig_1Hz = 0; trig_2Hz = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
